forwarding_hazard_unit: RTL

Control-side counterpart of the execute stage's operand-forwarding muxes. It shadows the register addresses and control bits of the ID/EX, EX/MEM and MEM/WB pipeline stages. From that state it drives aluInputAForwardingSel and aluInputBForwardingSel, and it detects load-use hazards, asserting a stall and inserting a bubble into its own ID/EX shadow stage. It sits beside the pipeline registers of the 8-bit pipelined core.

---
 rtl/hazard_pkg.sv | 21 ++
 rtl/fwd_select.sv | 23 ++
 rtl/forwarding_hazard_unit.sv | 71 +++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared select encodings, shadow-stage type and helpers for the forwarding/hazard unit
package hazard_pkg;
  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_EXMEM   = 2'b01;
  localparam logic [1:0] FWD_MEMWB   = 2'b10;
  // Addresses are held zero-extended to this width so one struct serves any REG_ADDR_W up to 8.
  localparam int MAX_ADDR_W = 8;
  typedef struct packed {
    logic [MAX_ADDR_W-1:0] rd;
    logic                  wr;
    logic                  mrd;
  } stage_t;
  function automatic logic is_zero(input logic en, input logic [MAX_ADDR_W-1:0] a);
    return en && a == '0;
  endfunction
  function automatic logic src_hit(input logic u1, input logic [MAX_ADDR_W-1:0] a1,
                                   input logic u2, input logic [MAX_ADDR_W-1:0] a2,
                                   input logic [MAX_ADDR_W-1:0] rd);
    return (u1 && a1 == rd) || (u2 && a2 == rd);
  endfunction
endpackage

// File: rtl/fwd_select.sv
// fwd_select: per-operand forwarding select for the instruction in EX
// Ports: uses/rs describe the EX operand; exmem and memwb_rd/memwb_wr are the older
// shadow stages; sel is 00 regfile, 01 EX/MEM result, 10 MEM/WB result.
// BYPASS=0 ties sel to the register file.
module fwd_select import hazard_pkg::*; #(
  parameter bit ZERO_REG_EN = 1'b1,
  parameter bit BYPASS      = 1'b1
) (
  input  logic                  uses,
  input  logic [MAX_ADDR_W-1:0] rs,
  input  stage_t                exmem,
  input  logic [MAX_ADDR_W-1:0] memwb_rd,
  input  logic                  memwb_wr,
  output logic [1:0]            sel
);
  logic live;
  // A load in EX/MEM only holds an address, so it is skipped and MEM/WB is tried instead.
  always_comb begin
    live = BYPASS && uses && !is_zero(ZERO_REG_EN, rs);
    sel  = (live && exmem.wr && !exmem.mrd && exmem.rd == rs) ? FWD_EXMEM :
           (live && memwb_wr && memwb_rd == rs) ? FWD_MEMWB : FWD_REGFILE;
  end
endmodule

// File: rtl/forwarding_hazard_unit.sv
// forwarding_hazard_unit: shadows ID/EX, EX/MEM, MEM/WB control, drives ALU forwarding selects and load-use stall
// Ports: clk; rst (async, active-low); id_* describe the instruction in ID; flush squashes it;
// aluInputAForwardingSel/aluInputBForwardingSel pick the EX operand source; stall holds PC and IF/ID.
// Macro FWD_BYPASS_EN: defined -> forwarding with single-bubble load-use stall;
// undefined -> selects tied to 00, stall until every producer has reached WB.
module forwarding_hazard_unit import hazard_pkg::*; #(
  parameter int REG_ADDR_W  = 3,
  parameter bit ZERO_REG_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  flush,
  output logic [1:0]            aluInputAForwardingSel,
  output logic [1:0]            aluInputBForwardingSel,
  output logic                  stall
);
`ifdef FWD_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  stage_t                idex, exmem;
  logic [MAX_ADDR_W-1:0] idex_rs1, idex_rs2, memwb_rd, r1, r2;
  logic                  idex_u1, idex_u2, memwb_wr, u1, u2, bubble;
  // With bypass only a load one stage ahead blocks; without it any writer not yet in WB does.
  always_comb begin
    r1     = MAX_ADDR_W'(id_rs1);
    r2     = MAX_ADDR_W'(id_rs2);
    u1     = id_uses_rs1 && !is_zero(ZERO_REG_EN, r1);
    u2     = id_uses_rs2 && !is_zero(ZERO_REG_EN, r2);
    stall  = !flush &&
             ((idex.wr && (idex.mrd || !BYPASS) && src_hit(u1, r1, u2, r2, idex.rd)) ||
              (!BYPASS && exmem.wr && src_hit(u1, r1, u2, r2, exmem.rd)));
    bubble = flush || stall;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      idex     <= '0;
      idex_rs1 <= '0;
      idex_rs2 <= '0;
      idex_u1  <= 1'b0;
      idex_u2  <= 1'b0;
      exmem    <= '0;
      memwb_rd <= '0;
      memwb_wr <= 1'b0;
    end else begin
      idex     <= '{rd: MAX_ADDR_W'(id_rd), wr: id_reg_write && !bubble, mrd: id_mem_read && !bubble};
      idex_rs1 <= r1;
      idex_rs2 <= r2;
      idex_u1  <= id_uses_rs1 && !bubble;
      idex_u2  <= id_uses_rs2 && !bubble;
      exmem    <= idex;
      memwb_rd <= exmem.rd;
      memwb_wr <= exmem.wr;
    end
  fwd_select #(.ZERO_REG_EN(ZERO_REG_EN), .BYPASS(BYPASS)) u_sel_a (
    .uses(idex_u1), .rs(idex_rs1), .exmem(exmem), .memwb_rd(memwb_rd), .memwb_wr(memwb_wr),
    .sel(aluInputAForwardingSel)
  );
  fwd_select #(.ZERO_REG_EN(ZERO_REG_EN), .BYPASS(BYPASS)) u_sel_b (
    .uses(idex_u2), .rs(idex_rs2), .exmem(exmem), .memwb_rd(memwb_rd), .memwb_wr(memwb_wr),
    .sel(aluInputBForwardingSel)
  );
endmodule
